reg_file: RTL

- 32-entry × 64-bit general-purpose register file for the single-cycle datapath.
- Two combinational read ports drive the ALU `A` and `B` operand inputs.
- One synchronous write port commits the writeback result (ALU result or memory load data) on the rising clock edge.
- Register X31 is the hardwired zero register (XZR): it always reads 0, and writes to it are discarded.

---
 rtl/reg_file.sv | 71 +++++++
 1 files changed

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_file
// Purpose  : 32x64 register file, two combinational read ports, one write port,
//            entry ZERO_REG hardwired to zero. Optional write-to-read bypass is
//            enabled by defining REG_FILE_WRITE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int                  c_DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] r_regs [c_DEPTH];
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;

    // The zero entry is never written, so it stays at its reset value.
    assign w_wr_en = reg_write && (write_reg != c_ZERO_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[write_reg] <= write_data;
        end
    end

    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (read_reg1 != c_ZERO_IDX) begin
            w_rd1 = r_regs[read_reg1];
`ifdef REG_FILE_WRITE_BYPASS_EN
            if (w_wr_en && rst_n && (read_reg1 == write_reg)) begin
                w_rd1 = write_data;
            end
`endif
        end
        if (read_reg2 != c_ZERO_IDX) begin
            w_rd2 = r_regs[read_reg2];
`ifdef REG_FILE_WRITE_BYPASS_EN
            if (w_wr_en && rst_n && (read_reg2 == write_reg)) begin
                w_rd2 = write_data;
            end
`endif
        end
    end

    assign read_data1 = w_rd1;
    assign read_data2 = w_rd2;

endmodule
`default_nettype wire
